// File: rtl/tx_pattern_pkg.sv
// Shared types and helpers for the TX test-pattern checker.
package tx_pattern_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StTrack,
        StLocked
    } state_e;

    // Default pattern words produced by the radio test-pattern generator.
    localparam logic [31:0] DefLoWord = 32'h0000_0000;
    localparam logic [31:0] DefHiWord = 32'hAAAA_AAAA;

    // Classified word: valid is set only for an exact LO or HI match.
    typedef struct packed {
        logic valid;
        logic lvl;
    } level_t;

    function automatic level_t classify(input logic [31:0] word,
                                        input logic [31:0] lo_word,
                                        input logic [31:0] hi_word);
        level_t r;
        r.valid = 1'b0;
        r.lvl   = 1'b0;
        if (word == lo_word) begin
            r.valid = 1'b1;
        end else if (word == hi_word) begin
            r.valid = 1'b1;
            r.lvl   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_pattern_checker_if.sv
// Control, sample and status bundle between the pattern checker and its host.
interface tx_pattern_checker_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             enable;
    logic             clear;
    logic [31:0]      sample_in;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sample_count;
    logic [31:0]      last_err_sample;

    // Host / generator side.
    modport master (
        output enable, clear, sample_in,
        input  locked, err_pulse, err_count, sample_count, last_err_sample
    );

    // Checker side.
    modport slave (
        input  enable, clear, sample_in,
        output locked, err_pulse, err_count, sample_count, last_err_sample
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear first, then increment unless already all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/tx_pattern_checker.sv
// Square-wave test-pattern checker: acquires phase, locks, counts and captures mismatches.
module tx_pattern_checker
    import tx_pattern_pkg::*;
#(
    parameter logic [31:0] LO_WORD     = DefLoWord,
    parameter logic [31:0] HI_WORD     = DefHiWord,
    parameter int unsigned HALF_PERIOD = 2,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 radio_clk,
    input  logic                 radio_rst,
    tx_pattern_checker_if.slave  bus
);
    localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned EW = $clog2(UNLOCK_ERRS + 1);

    state_e          state_q, state_d;
    logic            nlvl_q, nlvl_d;
    logic [PW-1:0]   npos_q, npos_d;
    logic            prev_lvl_q, prev_lvl_d;
    logic            prev_valid_q, prev_valid_d;
    logic [MW-1:0]   match_q, match_d;
    logic [EW-1:0]   cerr_q, cerr_d;
    logic            locked_q, locked_d;
    logic            err_pulse_q, err_pulse_d;
    logic [31:0]     last_err_q, last_err_d;

    logic            sample_inc, err_inc, capture;
    level_t          cls;
    logic            correct;
    logic [MW-1:0]   match_inc;
    logic [EW-1:0]   cerr_inc;

    // Prediction for the word after one of level lvl at position pos.
    function automatic logic [PW:0] step_pred(input logic lvl, input logic [PW-1:0] pos);
        if (pos == PW'(HALF_PERIOD - 1)) begin
            return {~lvl, {PW{1'b0}}};
        end
        return {lvl, pos + PW'(1)};
    endfunction

    assign cls       = classify(bus.sample_in, LO_WORD, HI_WORD);
    assign correct   = cls.valid && (cls.lvl == nlvl_q);
    assign match_inc = match_q + MW'(1);
    assign cerr_inc  = cerr_q + EW'(1);

    // Next-state, prediction and status decode.
    always_comb begin
        state_d      = state_q;
        nlvl_d       = nlvl_q;
        npos_d       = npos_q;
        prev_lvl_d   = prev_lvl_q;
        prev_valid_d = prev_valid_q;
        match_d      = match_q;
        cerr_d       = cerr_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        sample_inc   = 1'b0;
        err_inc      = 1'b0;
        capture      = 1'b0;

        if (!bus.enable) begin
            state_d  = StIdle;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d      = StSearch;
                    prev_valid_d = 1'b0;
                end
                StSearch: begin
                    if (cls.valid) begin
                        if (prev_valid_q && (cls.lvl != prev_lvl_q)) begin
                            // Level edge: this word is position 0 of its level.
                            {nlvl_d, npos_d} = step_pred(cls.lvl, {PW{1'b0}});
                            match_d          = '0;
                            state_d          = StTrack;
                        end
                        prev_lvl_d   = cls.lvl;
                        prev_valid_d = 1'b1;
                    end else begin
                        prev_valid_d = 1'b0;
                    end
                end
                StTrack: begin
                    if (correct) begin
                        {nlvl_d, npos_d} = step_pred(nlvl_q, npos_q);
                        match_d          = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_d  = StLocked;
                            locked_d = 1'b1;
                            cerr_d   = '0;
                        end
                    end else begin
                        state_d      = StSearch;
                        prev_lvl_d   = cls.lvl;
                        prev_valid_d = cls.valid;
                    end
                end
                StLocked: begin
                    // Phase is free-running once locked; errors do not re-align it.
                    sample_inc       = 1'b1;
                    {nlvl_d, npos_d} = step_pred(nlvl_q, npos_q);
                    if (correct) begin
                        cerr_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        capture     = 1'b1;
                        cerr_d      = cerr_inc;
                        if (cerr_inc == EW'(UNLOCK_ERRS)) begin
                            state_d      = StSearch;
                            locked_d     = 1'b0;
                            prev_lvl_d   = cls.lvl;
                            prev_valid_d = cls.valid;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Capture register: clear beats a simultaneous capture.
    always_comb begin
        last_err_d = last_err_q;
        if (bus.clear) begin
            last_err_d = '0;
        end else if (capture) begin
            last_err_d = bus.sample_in;
        end
    end

    // State and status registers with asynchronous reset.
    always_ff @(posedge radio_clk or posedge radio_rst) begin
        if (radio_rst) begin
            state_q      <= StIdle;
            nlvl_q       <= 1'b0;
            npos_q       <= '0;
            prev_lvl_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            match_q      <= '0;
            cerr_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            last_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            nlvl_q       <= nlvl_d;
            npos_q       <= npos_d;
            prev_lvl_q   <= prev_lvl_d;
            prev_valid_q <= prev_valid_d;
            match_q      <= match_d;
            cerr_q       <= cerr_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            last_err_q   <= last_err_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk_i   (radio_clk),
        .rst_i   (radio_rst),
        .inc_i   (err_inc),
        .clr_i   (bus.clear),
        .count_o (bus.err_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sample_cnt (
        .clk_i   (radio_clk),
        .rst_i   (radio_rst),
        .inc_i   (sample_inc),
        .clr_i   (bus.clear),
        .count_o (bus.sample_count)
    );

    assign bus.locked          = locked_q;
    assign bus.err_pulse       = err_pulse_q;
    assign bus.last_err_sample = last_err_q;
endmodule
